// File: rtl/ldpc_3gpp_enc_out_sched_if.sv
// Bus between the encoder output sinks, the output scheduler and the downstream stream consumer.
// The master side drives the sink outputs and downstream ready; the slave side is the scheduler.
interface ldpc_3gpp_enc_out_sched_if #(
  parameter int pN_ENG = 4,
  parameter int pDAT_W = 8,
  parameter int pTAG_W = 4
);
  logic [pN_ENG-1:0]        ifull;
  logic [pN_ENG-1:0]        isop;
  logic [pN_ENG-1:0]        ieop;
  logic [pN_ENG-1:0]        ival;
  logic [pN_ENG*pDAT_W-1:0] idat;
  logic [pN_ENG*pTAG_W-1:0] itag;
  logic [pN_ENG-1:0]        oreq;
  logic                     ordy;
  logic                     oval;
  logic                     osop;
  logic                     oeop;
  logic [pDAT_W-1:0]        odat;
  logic [pTAG_W-1:0]        otag;

  modport master (
    output ifull, isop, ieop, ival, idat, itag, ordy,
    input  oreq, oval, osop, oeop, odat, otag
  );

  modport slave (
    input  ifull, isop, ieop, ival, idat, itag, ordy,
    output oreq, oval, osop, oeop, odat, otag
  );
endinterface

// File: rtl/ldpc_3gpp_enc_out_sched.sv
// Round-robin scheduler that drains whole codewords from pN_ENG encoder output sinks into one
// ready/valid stream, pacing sink reads with credits against a local output FIFO.
module ldpc_3gpp_enc_out_sched #(
  parameter int pN_ENG  = 4,
  parameter int pDAT_W  = 8,
  parameter int pTAG_W  = 4,
  parameter int pLAT    = 3,
  parameter int pFIFO_D = 8
) (
  input  logic                      iclk,
  input  logic                      ireset,
  input  logic                      iclkena,
  ldpc_3gpp_enc_out_sched_if.slave  bus,
  output logic [$clog2(pN_ENG)-1:0] ogrant,
  output logic                      obusy
);

  localparam int G_W = $clog2(pN_ENG);
  localparam int A_W = $clog2(pFIFO_D);
  localparam int W_W = 2 + pDAT_W + pTAG_W;
  localparam int C_W = A_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             r_state, w_state_nxt;
  logic [G_W-1:0]     r_grant, r_rr_ptr;
  logic [G_W-1:0]     w_grant_nxt, w_rr_nxt, w_pick, w_cand;
  logic [G_W:0]       w_sum;
  logic               w_any, w_req, w_last, w_credit, w_push, w_pop;
  logic [pN_ENG-1:0]  w_oreq;
  logic [pLAT-1:0]    r_inflight_sr;
  logic [C_W-1:0]     w_inflight, w_used;
  logic [A_W:0]       r_wptr, r_rptr, w_count;
  logic [W_W-1:0]     r_mem [pFIFO_D];
  logic [W_W-1:0]     w_head;

  // Round-robin search; iterating from the far end lets the nearest ready engine win.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_rr_ptr;
    w_sum  = '0;
    w_cand = '0;
    for (int i = pN_ENG - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_rr_ptr} + (G_W+1)'(i);
      if (w_sum >= (G_W+1)'(pN_ENG))
        w_sum = w_sum - (G_W+1)'(pN_ENG);
      w_cand = w_sum[G_W-1:0];
      if (bus.ifull[w_cand]) begin
        w_any  = 1'b1;
        w_pick = w_cand;
      end
    end
  end

  // Words requested but not yet landed in the FIFO still consume credit.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < pLAT; i++)
      w_inflight = w_inflight + C_W'(r_inflight_sr[i]);
  end

  assign w_count  = r_wptr - r_rptr;
  assign w_used   = C_W'(w_count) + w_inflight;
  assign w_credit = (w_used < C_W'(pFIFO_D));

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_req       = 1'b0;
    w_last      = bus.ival[r_grant] & bus.ieop[r_grant];
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_req = bus.ifull[r_grant] & w_credit & iclkena;
        if (!bus.ifull[r_grant])
          w_state_nxt = w_last ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (w_last)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if ((r_state != IDLE) && (w_state_nxt == IDLE))
      w_rr_nxt = (r_grant == G_W'(pN_ENG - 1)) ? '0 : r_grant + 1'b1;
  end

  always_comb begin
    w_oreq          = '0;
    w_oreq[r_grant] = w_req;
  end

  assign w_push = (r_state != IDLE) & bus.ival[r_grant];
  assign w_pop  = bus.oval & bus.ordy;

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_inflight_sr <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else if (iclkena) begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_inflight_sr <= pLAT'({r_inflight_sr, w_req});
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
    end
  end

  // FIFO storage carries data only, so it is left out of reset.
  always_ff @(posedge iclk) begin
    if (iclkena && w_push)
      r_mem[r_wptr[A_W-1:0]] <= {bus.isop[r_grant], bus.ieop[r_grant],
                                 bus.idat[r_grant*pDAT_W +: pDAT_W],
                                 bus.itag[r_grant*pTAG_W +: pTAG_W]};
  end

  assign w_head   = r_mem[r_rptr[A_W-1:0]];
  assign bus.oval = (w_count != '0);
  assign bus.osop = bus.oval & w_head[W_W-1];
  assign bus.oeop = bus.oval & w_head[W_W-2];
  assign bus.odat = w_head[pTAG_W +: pDAT_W];
  assign bus.otag = w_head[pTAG_W-1:0];
  assign bus.oreq = w_oreq;
  assign ogrant   = r_grant;
  assign obusy    = (r_state != IDLE);

endmodule

// File: tb/tb_ldpc_3gpp_enc_out_sched.sv
// Directed bench for ldpc_3gpp_enc_out_sched: behavioural sink models per engine, a beat/grant
// scoreboard and bench-side occupancy/credit tracking.
module tb_ldpc_3gpp_enc_out_sched;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TW  = 4;
  localparam int LAT = 3;
  localparam int FD  = 8;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [TW-1:0] tag;
    logic [DW-1:0] dat;
  } beat_t;

  logic         iclk = 1'b0;
  logic         ireset;
  logic         iclkena;
  logic [1:0]   ogrant;
  logic         obusy;

  ldpc_3gpp_enc_out_sched_if #(.pN_ENG(N), .pDAT_W(DW), .pTAG_W(TW)) bus ();

  ldpc_3gpp_enc_out_sched #(
    .pN_ENG(N), .pDAT_W(DW), .pTAG_W(TW), .pLAT(LAT), .pFIFO_D(FD)
  ) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .bus     (bus.slave),
    .ogrant  (ogrant),
    .obusy   (obusy)
  );

  always #5 iclk = ~iclk;

  function automatic logic [DW-1:0] wdat(int k, int cw, int i);
    return DW'(k * 64 + cw * 16 + i);
  endfunction

  function automatic logic [TW-1:0] wtag(int k, int cw);
    return TW'(k * 3 + cw * 5 + 1);
  endfunction

  // Sink models: ofull while a codeword is pending, one word pLAT cycles after each request.
  int              arm_cnt [N];
  int              cw_len  [N];
  int              cw_idx  [N];
  int              cur_cw  [N];
  int              req_cnt [N];
  logic [N-1:0]    m_full;
  logic [LAT-1:0]  p_vld [N];
  logic [LAT-1:0]  p_sop [N];
  logic [LAT-1:0]  p_eop [N];
  logic [DW-1:0]   p_dat [N][LAT];
  logic [TW-1:0]   p_tag [N][LAT];

  always @(posedge iclk) begin
    for (int k = 0; k < N; k++) begin
      if (ireset) begin
        m_full[k]  <= 1'b0;
        p_vld[k]   <= '0;
        req_cnt[k] <= 0;
      end else begin
        p_vld[k] <= {p_vld[k][LAT-2:0], m_full[k] & bus.oreq[k]};
        p_sop[k] <= {p_sop[k][LAT-2:0], req_cnt[k] == 0};
        p_eop[k] <= {p_eop[k][LAT-2:0], req_cnt[k] == cw_len[k] - 1};
        for (int s = LAT - 1; s > 0; s--) begin
          p_dat[k][s] <= p_dat[k][s-1];
          p_tag[k][s] <= p_tag[k][s-1];
        end
        p_dat[k][0] <= wdat(k, cur_cw[k], req_cnt[k]);
        p_tag[k][0] <= wtag(k, cur_cw[k]);
        if (m_full[k] && bus.oreq[k]) begin
          req_cnt[k] <= req_cnt[k] + 1;
          if (req_cnt[k] == cw_len[k] - 1)
            m_full[k] <= 1'b0;
        end else if (!m_full[k] && (cw_idx[k] < arm_cnt[k]) && (p_vld[k] == '0)) begin
          m_full[k]  <= 1'b1;
          req_cnt[k] <= 0;
          cur_cw[k]  <= cw_idx[k];
          cw_idx[k]  <= cw_idx[k] + 1;
        end
      end
    end
  end

  assign bus.ifull = m_full;

  always_comb begin
    bus.ival = '0;
    bus.isop = '0;
    bus.ieop = '0;
    bus.idat = '0;
    bus.itag = '0;
    for (int k = 0; k < N; k++) begin
      bus.ival[k]            = p_vld[k][LAT-1];
      bus.isop[k]            = p_sop[k][LAT-1];
      bus.ieop[k]            = p_eop[k][LAT-1];
      bus.idat[k*DW +: DW]   = p_dat[k][LAT-1];
      bus.itag[k*TW +: TW]   = p_tag[k][LAT-1];
    end
  end

  // Scoreboard and bench-side bookkeeping
  int    n_chk = 0;
  int    n_err = 0;
  beat_t exp_q[$];
  int    exp_g[$];
  int    tb_occ = 0;
  int    req_total = 0;
  int    beats_out = 0;
  logic  prev_busy = 1'b0;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic arm(int k, int len);
    beat_t b;
    cw_len[k] = len;
    for (int i = 0; i < len; i++) begin
      b.sop = (i == 0);
      b.eop = (i == len - 1);
      b.tag = wtag(k, arm_cnt[k]);
      b.dat = wdat(k, arm_cnt[k], i);
      exp_q.push_back(b);
    end
    exp_g.push_back(k);
    arm_cnt[k] = arm_cnt[k] + 1;
  endtask

  // One clock: checks outputs mid-cycle, then returns 1 time unit after the next rising edge.
  task automatic tick();
    logic [N-1:0] gm;
    beat_t        b;
    int           push;
    int           pop;
    @(negedge iclk);
    if (!ireset) begin
      if (obusy && !prev_busy) begin
        if (exp_g.size() == 0) check("grant_extra", 32'(exp_g.size() != 0), 32'd1);
        else                   check("ogrant", 32'(ogrant), 32'(exp_g.pop_front()));
      end
      gm = N'(1) << ogrant;
      if (obusy) check("stray_ival", 32'(bus.ival & ~gm), 32'd0);
      check("oval_occ", 32'(bus.oval), 32'(tb_occ != 0));
      if (bus.oval && bus.ordy) begin
        if (exp_q.size() == 0) check("beat_extra", 32'(exp_q.size() != 0), 32'd1);
        else begin
          b = exp_q.pop_front();
          check("beat", 32'({bus.osop, bus.oeop, bus.otag, bus.odat}), 32'(b));
        end
        beats_out++;
      end
      push = (obusy && bus.ival[ogrant]) ? 1 : 0;
      pop  = (bus.oval && bus.ordy) ? 1 : 0;
      tb_occ    = tb_occ + push - pop;
      req_total = req_total + $countones(bus.oreq);
      check("fifo_ovf", 32'(tb_occ <= FD), 32'd1);
      check("credit", 32'((req_total - beats_out) <= FD), 32'd1);
    end else begin
      tb_occ    = 0;
      req_total = 0;
      beats_out = 0;
    end
    prev_busy = obusy;
    @(posedge iclk);
    #1;
  endtask

  task automatic wait_done(string tag, int budget, bit toggle);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    while (!done && n < budget) begin
      if (toggle) bus.ordy = ~bus.ordy;
      tick();
      n++;
      done = (exp_q.size() == 0) && (exp_g.size() == 0) && !obusy && !bus.oval;
    end
    check(tag, 32'(done), 32'd1);
    bus.ordy = 1'b1;
  endtask

  initial begin
    int n;
    iclkena  = 1'b1;
    ireset   = 1'b1;
    bus.ordy = 1'b0;
    for (int k = 0; k < N; k++) begin
      arm_cnt[k] = 0;
      cw_len[k]  = 1;
      cw_idx[k]  = 0;
      cur_cw[k]  = 0;
    end
    tick();
    tick();
    check("rst_oval", 32'(bus.oval), 32'd0);
    check("rst_osop", 32'(bus.osop), 32'd0);
    check("rst_oeop", 32'(bus.oeop), 32'd0);
    check("rst_oreq", 32'(bus.oreq), 32'd0);
    check("rst_obusy", 32'(obusy), 32'd0);
    check("rst_ogrant", 32'(ogrant), 32'd0);
    ireset = 1'b0;
    tick();

    // Single engine, latency and sustained rate
    bus.ordy = 1'b1;
    arm(0, 24);
    tick();
    check("t1_ifull", 32'(bus.ifull), 32'h1);
    check("t1_idle_oreq", 32'(bus.oreq), 32'h0);
    check("t1_idle_busy", 32'(obusy), 32'd0);
    tick();
    check("t1_oreq", 32'(bus.oreq), 32'h1);
    check("t1_busy", 32'(obusy), 32'd1);
    check("t1_grant", 32'(ogrant), 32'd0);
    repeat (3) tick();
    check("t1_oval_early", 32'(bus.oval), 32'd0);
    tick();
    check("t1_oval_first", 32'(bus.oval), 32'd1);
    check("t1_osop_first", 32'(bus.osop), 32'd1);
    check("t1_odat_first", 32'(bus.odat), 32'(wdat(0, 0, 0)));
    repeat (23) tick();
    check("t1_last_oval", 32'(bus.oval), 32'd1);
    check("t1_last_oeop", 32'(bus.oeop), 32'd1);
    check("t1_last_odat", 32'(bus.odat), 32'(wdat(0, 0, 23)));
    wait_done("t1_done", 50, 1'b0);
    check("t1_busy_end", 32'(obusy), 32'd0);

    // Two engines ready together after reset: 1 then 3
    ireset = 1'b1;
    tick();
    ireset = 1'b0;
    tick();
    arm(1, 10);
    arm(3, 12);
    wait_done("t2_done", 200, 1'b0);

    // All engines continuously full, two rounds
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++)
        arm(k, 6);
    wait_done("t3_done", 400, 1'b0);

    // Back-pressure: FIFO fills to depth and requests stop
    arm(1, 40);
    repeat (10) tick();
    bus.ordy = 1'b0;
    repeat (20) tick();
    check("t4_occ", 32'(tb_occ), 32'(FD));
    check("t4_oreq", 32'(bus.oreq), 32'h0);
    check("t4_ival", 32'(bus.ival), 32'h0);
    check("t4_oval", 32'(bus.oval), 32'd1);
    check("t4_outstanding", 32'(req_total - beats_out), 32'(FD));
    bus.ordy = 1'b1;
    wait_done("t4_done", 300, 1'b0);

    // Alternating ready, long codeword
    bus.ordy = 1'b0;
    arm(2, 48);
    wait_done("t5_done", 400, 1'b1);

    // Reset while words are buffered
    bus.ordy = 1'b0;
    arm(3, 30);
    n = 0;
    while (tb_occ != 5 && n < 50) begin
      tick();
      n++;
    end
    check("t6_occ5", 32'(tb_occ), 32'd5);
    check("t6_busy_pre", 32'(obusy), 32'd1);
    ireset = 1'b1;
    #1;
    check("t6_oval", 32'(bus.oval), 32'd0);
    check("t6_osop", 32'(bus.osop), 32'd0);
    check("t6_oeop", 32'(bus.oeop), 32'd0);
    check("t6_oreq", 32'(bus.oreq), 32'h0);
    check("t6_obusy", 32'(obusy), 32'd0);
    check("t6_ogrant", 32'(ogrant), 32'd0);
    exp_q.delete();
    exp_g.delete();
    tick();
    ireset   = 1'b0;
    bus.ordy = 1'b1;
    tick();
    check("t6_no_partial", 32'(bus.oval), 32'd0);
    arm(3, 10);
    wait_done("t6_done", 100, 1'b0);
    check("t6_busy_end", 32'(obusy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
